// File: rtl/emu_pkg.sv
// Shared definitions for the emulation chip tester: stepper FSM states,
// status-register bit positions and the synchroniser settle time.
package emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_SETTLE,
    ST_CAPTURE
  } emu_state_e;

  // Bit positions inside the status byte returned at address NUM_OUT_BYTES.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;

  // Cycles to wait after the last DUT clock so the two-flop synchroniser
  // has passed the final DUT response through before capture.
  localparam int SETTLE_CYC = 3;

endpackage

// File: rtl/emu_clk_stepper.sv
// Clock-stepping sequencer: on start, strobes an apply, issues COUNT DUT
// clock pulses of HALF_CYC high + HALF_CYC low cycles, waits for the
// synchroniser to settle, then strobes a capture and sets a sticky done.
module emu_clk_stepper
  import emu_pkg::*;
#(
  parameter int HALF_CYC = 1
) (
  input  logic       clk_emu,
  input  logic       reset_emu,
  input  logic       start_i,
  input  logic [7:0] count_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       xclk_o,
  output logic       apply_o,
  output logic       capture_o
);

  localparam logic [7:0] HALF_LAST   = 8'(HALF_CYC - 1);
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYC - 1);

  emu_state_e state_q;
  logic [8:0] cyc_q;     // remaining DUT clock pulses, 1..256
  logic [7:0] half_q;    // cycles left in the current half-period
  logic [1:0] settle_q;  // cycles left in SETTLE
  logic       busy_q;
  logic       done_q;
  logic       xclk_q;
  logic       apply_q;
  logic       capture_q;

  // Sequencer FSM; every output is a flop set on entry to the state it marks.
  always_ff @(posedge clk_emu) begin
    if (reset_emu) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      half_q    <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      xclk_q    <= 1'b0;
      apply_q   <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // and the later assignment in a branch cleanly overrides these defaults.
      apply_q   <= 1'b0;
      capture_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            // A step count of zero means a full 256 pulses.
            cyc_q   <= (count_i == 8'd0) ? 9'd256 : {1'b0, count_i};
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            apply_q <= 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          xclk_q  <= 1'b1;
          half_q  <= HALF_LAST;
          state_q <= ST_CLK_HI;
        end
        ST_CLK_HI: begin
          if (half_q == 8'd0) begin
            xclk_q  <= 1'b0;
            half_q  <= HALF_LAST;
            state_q <= ST_CLK_LO;
          end else begin
            half_q <= half_q - 8'd1;
          end
        end
        ST_CLK_LO: begin
          if (half_q == 8'd0) begin
            cyc_q <= cyc_q - 9'd1;
            if (cyc_q != 9'd1) begin
              xclk_q  <= 1'b1;
              half_q  <= HALF_LAST;
              state_q <= ST_CLK_HI;
            end else begin
              settle_q <= SETTLE_LAST;
              state_q  <= ST_SETTLE;
            end
          end else begin
            half_q <= half_q - 8'd1;
          end
        end
        ST_SETTLE: begin
          if (settle_q == 2'd0) begin
            capture_q <= 1'b1;
            state_q   <= ST_CAPTURE;
          end else begin
            settle_q <= settle_q - 2'd1;
          end
        end
        ST_CAPTURE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          xclk_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign xclk_o    = xclk_q;
  assign apply_o   = apply_q;
  assign capture_o = capture_q;

endmodule

// File: rtl/emu_chip_tester.sv
// Emulation chip tester: host-writable stimulus shadow bank, registered DUT
// stimulus, synchronised DUT response capture bank, registered read port and
// an automatic load/clock/capture stepper.
module emu_chip_tester
  import emu_pkg::*;
#(
  parameter int NUM_STIM_BYTES = 2,
  parameter int NUM_OUT_BYTES  = 2,
  parameter int ADDR_W         = 3,
  parameter int HALF_CYC       = 1
) (
  input  logic                        clk_emu,
  input  logic                        reset_emu,
  input  logic [7:0]                  Din_emu,
  input  logic [ADDR_W-1:0]           Addr_emu,
  input  logic                        wr_emu,
  input  logic                        load_emu,
  input  logic                        get_emu,
  input  logic                        step_emu,
  output logic [7:0]                  Dout_emu,
  output logic                        busy_emu,
  output logic [8*NUM_STIM_BYTES-1:0] dut_in,
  input  logic [8*NUM_OUT_BYTES-1:0]  dut_out,
  output logic                        xclk_dut
);

  logic [8*NUM_STIM_BYTES-1:0] shadow_q;
  logic [8*NUM_STIM_BYTES-1:0] dut_in_q;
  logic [8*NUM_OUT_BYTES-1:0]  sync1_q;
  logic [8*NUM_OUT_BYTES-1:0]  sync2_q;
  logic [8*NUM_OUT_BYTES-1:0]  cap_q;
  logic [7:0]                  dout_q;
  logic [7:0]                  rd_d;

  logic busy_w;
  logic done_w;
  logic apply_w;
  logic capture_w;
  logic start_w;
  logic load_w;
  logic get_w;

  // Commands are ignored while a step runs; step beats load beats get.
  assign start_w = step_emu & ~busy_w;
  assign load_w  = load_emu & ~step_emu & ~busy_w;
  assign get_w   = get_emu & ~step_emu & ~load_emu & ~busy_w;

  emu_clk_stepper #(
    .HALF_CYC (HALF_CYC)
  ) u_stepper (
    .clk_emu   (clk_emu),
    .reset_emu (reset_emu),
    .start_i   (start_w),
    .count_i   (Din_emu),
    .busy_o    (busy_w),
    .done_o    (done_w),
    .xclk_o    (xclk_dut),
    .apply_o   (apply_w),
    .capture_o (capture_w)
  );

  // Two-flop synchroniser on every asynchronous DUT output bit.
  always_ff @(posedge clk_emu) begin
    if (reset_emu) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dut_out;
      sync2_q <= sync1_q;
    end
  end

  // Host writes into the stimulus shadow bank; out-of-range addresses drop.
  always_ff @(posedge clk_emu) begin
    // NOTE: the shadow bank is reset explicitly because its contents reach
    // the DUT pins through a load, so an unknown power-up value would be visible.
    if (reset_emu) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STIM_BYTES; k++) begin
        if (wr_emu && (Addr_emu == ADDR_W'(k))) begin
          shadow_q[8*k +: 8] <= Din_emu;
        end
      end
    end
  end

  // DUT stimulus register, refreshed by a manual load or the stepper's apply.
  always_ff @(posedge clk_emu) begin
    if (reset_emu) begin
      dut_in_q <= '0;
    end else if (apply_w || load_w) begin
      dut_in_q <= shadow_q;
    end
  end

  // Capture bank, refreshed by a manual get or the stepper's capture.
  always_ff @(posedge clk_emu) begin
    if (reset_emu) begin
      cap_q <= '0;
    end else if (capture_w || get_w) begin
      cap_q <= sync2_q;
    end
  end

  // Read mux: capture bytes, then the status byte, zero elsewhere.
  always_comb begin
    // NOTE: rd_d gets a default before any conditional so no latch is inferred.
    rd_d = 8'h00;
    for (int k = 0; k < NUM_OUT_BYTES; k++) begin
      if (Addr_emu == ADDR_W'(k)) begin
        rd_d = cap_q[8*k +: 8];
      end
    end
    if (Addr_emu == ADDR_W'(NUM_OUT_BYTES)) begin
      rd_d                = 8'h00;
      rd_d[STAT_BUSY_BIT] = busy_w;
      rd_d[STAT_DONE_BIT] = done_w;
    end
  end

  // Registered read data, one cycle behind the address.
  always_ff @(posedge clk_emu) begin
    if (reset_emu) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= rd_d;
    end
  end

  assign Dout_emu = dout_q;
  assign busy_emu = busy_w;
  assign dut_in   = dut_in_q;

endmodule

// File: tb/tb_emu_chip_tester.sv
// Self-checking bench for emu_chip_tester with randomized stimulus against a
// behavioural model: shadow/stimulus/capture byte images plus arithmetic
// expectations for step timing.
module tb_emu_chip_tester;

  localparam int NS     = 2;
  localparam int NO     = 2;
  localparam int AW     = 3;
  localparam int HALF   = 2;
  localparam int SETTLE = 3;

  logic            clk_emu = 1'b0;
  logic            reset_emu;
  logic [7:0]      Din_emu;
  logic [AW-1:0]   Addr_emu;
  logic            wr_emu;
  logic            load_emu;
  logic            get_emu;
  logic            step_emu;
  logic [7:0]      Dout_emu;
  logic            busy_emu;
  logic [8*NS-1:0] dut_in;
  logic [8*NO-1:0] dut_out;
  logic            xclk_dut;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state.
  logic [8*NS-1:0] shadow_m;
  logic [8*NS-1:0] dut_in_m;
  logic [8*NO-1:0] cap_m;

  emu_chip_tester #(
    .NUM_STIM_BYTES (NS),
    .NUM_OUT_BYTES  (NO),
    .ADDR_W         (AW),
    .HALF_CYC       (HALF)
  ) dut (
    .clk_emu   (clk_emu),
    .reset_emu (reset_emu),
    .Din_emu   (Din_emu),
    .Addr_emu  (Addr_emu),
    .wr_emu    (wr_emu),
    .load_emu  (load_emu),
    .get_emu   (get_emu),
    .step_emu  (step_emu),
    .Dout_emu  (Dout_emu),
    .busy_emu  (busy_emu),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .xclk_dut  (xclk_dut)
  );

  always #5 clk_emu = ~clk_emu;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_emu);
    #1;
  endtask

  task automatic read_byte(input logic [AW-1:0] a, output logic [7:0] d);
    Addr_emu = a;
    tick();
    d = Dout_emu;
  endtask

  task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] d);
    int ai;
    ai       = int'(a);
    Addr_emu = a;
    Din_emu  = d;
    wr_emu   = 1'b1;
    tick();
    wr_emu   = 1'b0;
    if (ai < NS) shadow_m[8*ai +: 8] = d;
  endtask

  task automatic pulse_load();
    load_emu = 1'b1;
    tick();
    load_emu = 1'b0;
    dut_in_m = shadow_m;
  endtask

  task automatic do_reset();
    reset_emu = 1'b1;
    Din_emu = '0; Addr_emu = '0; wr_emu = 0; load_emu = 0; get_emu = 0; step_emu = 0;
    repeat (3) tick();
    reset_emu = 1'b0;
    shadow_m = '0; dut_in_m = '0; cap_m = '0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    dut_out = 16'h0000;
    do_reset();
    read_byte(3'(NO), d);
    checks_total++; if (d !== 8'h00) $display("FAIL reset_status: got %h want 00", d); else checks_passed++;
    checks_total++; if (busy_emu !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_emu); else checks_passed++;
    checks_total++; if (xclk_dut !== 1'b0) $display("FAIL reset_xclk: got %b want 0", xclk_dut); else checks_passed++;
    checks_total++; if (dut_in !== '0) $display("FAIL reset_dut_in: got %h want 0", dut_in); else checks_passed++;
    for (int a = 0; a < NO; a++) begin
      read_byte(3'(a), d);
      checks_total++; if (d !== 8'h00) $display("FAIL reset_cap%0d: got %h want 00", a, d); else checks_passed++;
    end
  endtask

  task automatic test_write_load();
    logic [2:0] a;
    logic [7:0] v;
    write_byte(3'd0, 8'hA5);
    write_byte(3'd1, 8'h3C);
    checks_total++; if (dut_in !== dut_in_m) $display("FAIL write_no_effect: got %h want %h", dut_in, dut_in_m); else checks_passed++;
    pulse_load();
    checks_total++; if (dut_in !== 16'h3CA5) $display("FAIL load_3CA5: got %h want 3ca5", dut_in); else checks_passed++;
    write_byte(3'd5, 8'($urandom));
    pulse_load();
    checks_total++; if (dut_in !== 16'h3CA5) $display("FAIL write_oob: got %h want 3ca5", dut_in); else checks_passed++;
    for (int i = 0; i < 6; i++) begin
      a = 3'($urandom_range(0, 7));
      v = 8'($urandom);
      write_byte(a, v);
      checks_total++; if (dut_in !== dut_in_m) $display("FAIL rand_write_hold%0d: got %h want %h", i, dut_in, dut_in_m); else checks_passed++;
      pulse_load();
      checks_total++; if (dut_in !== dut_in_m) $display("FAIL rand_load%0d: got %h want %h", i, dut_in, dut_in_m); else checks_passed++;
    end
  endtask

  task automatic test_get();
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      dut_out = 16'($urandom);
      repeat (3) tick();
      get_emu = 1'b1;
      tick();
      get_emu = 1'b0;
      cap_m = dut_out;
      for (int a = 0; a < NO; a++) begin
        read_byte(3'(a), d);
        checks_total++; if (d !== cap_m[8*a +: 8]) $display("FAIL get%0d_byte%0d: got %h want %h", i, a, d, cap_m[8*a +: 8]); else checks_passed++;
      end
      read_byte(3'($urandom_range(NO + 1, 7)), d);
      checks_total++; if (d !== 8'h00) $display("FAIL get%0d_unmapped: got %h want 00", i, d); else checks_passed++;
    end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    dut_out = ~cap_m;
    write_byte(3'd0, ~shadow_m[7:0]);
    repeat (3) tick();
    load_emu = 1'b1;
    get_emu  = 1'b1;
    tick();
    load_emu = 1'b0;
    get_emu  = 1'b0;
    dut_in_m = shadow_m;
    checks_total++; if (dut_in !== dut_in_m) $display("FAIL prio_load: got %h want %h", dut_in, dut_in_m); else checks_passed++;
    read_byte(3'd0, d);
    checks_total++; if (d !== cap_m[7:0]) $display("FAIL prio_get_ignored: got %h want %h", d, cap_m[7:0]); else checks_passed++;
  endtask

  // mode 0: plain step; 1: write/load/step/get injected while busy;
  // 2: dut_out inverted during the third SETTLE cycle.
  task automatic run_step(input logic [7:0] cnt, input int mode, input string tag);
    int n, exp_busy, busy_cycles, pulses, bad_runs, last_rise, last_fall, first_rise;
    logic prev_x;
    logic [7:0] d;
    logic [8*NS-1:0] applied;
    int ia;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    exp_busy = 1 + 2 * HALF * n + SETTLE + 1;
    busy_cycles = 0; pulses = 0; bad_runs = 0; last_rise = 0; last_fall = 0; first_rise = 0;
    prev_x = 1'b0;
    cap_m = dut_out;
    applied = shadow_m;
    Addr_emu = 3'(NO);
    Din_emu  = cnt;
    step_emu = 1'b1;
    tick();
    step_emu = 1'b0;
    while (busy_emu === 1'b1 && busy_cycles < 3000) begin
      busy_cycles++;
      if (xclk_dut === 1'b1 && !prev_x) begin
        if (pulses > 0 && (busy_cycles - last_fall) != HALF) bad_runs++;
        if (pulses == 0) first_rise = busy_cycles;
        last_rise = busy_cycles;
        pulses++;
      end
      if (xclk_dut !== 1'b1 && prev_x) begin
        if ((busy_cycles - last_rise) != HALF) bad_runs++;
        last_fall = busy_cycles;
      end
      prev_x = (xclk_dut === 1'b1);
      if (busy_cycles == 4) begin
        checks_total++; if (Dout_emu !== 8'h01) $display("FAIL %s_status_busy: got %h want 01", tag, Dout_emu); else checks_passed++;
      end
      if (mode == 1 && busy_cycles == 10) begin
        ia = $urandom_range(0, NS - 1);
        Addr_emu = 3'(ia);
        Din_emu  = 8'($urandom);
        shadow_m[8*ia +: 8] = Din_emu;
        wr_emu = 1'b1; load_emu = 1'b1; step_emu = 1'b1; get_emu = 1'b1;
      end
      if (mode == 2 && busy_cycles == exp_busy - 1) dut_out = ~dut_out;
      tick();
      wr_emu = 1'b0; load_emu = 1'b0; step_emu = 1'b0; get_emu = 1'b0;
      Addr_emu = 3'(NO);
    end
    checks_total++; if (busy_emu !== 1'b0) $display("FAIL %s_timeout: busy still %b after %0d cycles", tag, busy_emu, busy_cycles); else checks_passed++;
    checks_total++; if (busy_cycles != exp_busy) $display("FAIL %s_busy_len: got %0d want %0d", tag, busy_cycles, exp_busy); else checks_passed++;
    checks_total++; if (pulses != n) $display("FAIL %s_pulses: got %0d want %0d", tag, pulses, n); else checks_passed++;
    checks_total++; if (bad_runs != 0 || first_rise != 2) $display("FAIL %s_pulse_shape: bad runs %0d first rise %0d want 0 and 2", tag, bad_runs, first_rise); else checks_passed++;
    checks_total++; if ((busy_cycles - last_fall) != HALF + SETTLE) $display("FAIL %s_tail: got %0d want %0d", tag, busy_cycles - last_fall, HALF + SETTLE); else checks_passed++;
    tick();
    checks_total++; if (Dout_emu !== 8'h02) $display("FAIL %s_status_done: got %h want 02", tag, Dout_emu); else checks_passed++;
    dut_in_m = applied;
    checks_total++; if (dut_in !== dut_in_m) $display("FAIL %s_dut_in: got %h want %h", tag, dut_in, dut_in_m); else checks_passed++;
    for (int a = 0; a < NO; a++) begin
      read_byte(3'(a), d);
      checks_total++; if (d !== cap_m[8*a +: 8]) $display("FAIL %s_cap%0d: got %h want %h", tag, a, d, cap_m[8*a +: 8]); else checks_passed++;
    end
  endtask

  task automatic test_step_basic();
    dut_out = 16'($urandom);
    repeat (3) tick();
    run_step(8'd3, 0, "step3");
  endtask

  task automatic test_capture_window();
    dut_out = 16'hBEEF;
    repeat (3) tick();
    run_step(8'd1, 2, "cap_beef");
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    int highs;
    do_reset();
    dut_out = 16'h5A5A;
    write_byte(3'd0, 8'h77);
    Din_emu  = 8'd4;
    step_emu = 1'b1;
    tick();
    step_emu = 1'b0;
    repeat (5) tick();
    checks_total++; if (xclk_dut !== 1'b1 || busy_emu !== 1'b1) $display("FAIL abort_in_clk_hi: xclk %b busy %b want 1 1", xclk_dut, busy_emu); else checks_passed++;
    reset_emu = 1'b1;
    tick();
    checks_total++; if (busy_emu !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_emu); else checks_passed++;
    checks_total++; if (xclk_dut !== 1'b0) $display("FAIL abort_xclk: got %b want 0", xclk_dut); else checks_passed++;
    reset_emu = 1'b0;
    shadow_m = '0; dut_in_m = '0; cap_m = '0;
    highs = 0;
    Addr_emu = 3'(NO);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (xclk_dut !== 1'b0 || busy_emu !== 1'b0) highs++;
    end
    checks_total++; if (highs != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", highs); else checks_passed++;
    checks_total++; if (Dout_emu !== 8'h00) $display("FAIL abort_status: got %h want 00", Dout_emu); else checks_passed++;
    for (int a = 0; a < NO; a++) begin
      read_byte(3'(a), d);
      checks_total++; if (d !== cap_m[8*a +: 8]) $display("FAIL abort_cap%0d: got %h want %h", a, d, cap_m[8*a +: 8]); else checks_passed++;
    end
  endtask

  task automatic test_random_steps();
    for (int i = 0; i < 3; i++) begin
      write_byte(3'd0, 8'($urandom));
      write_byte(3'd1, 8'($urandom));
      dut_out = 16'($urandom);
      repeat (3) tick();
      run_step(8'($urandom_range(1, 6)), 0, "rand_step");
    end
  endtask

  task automatic test_long_step();
    dut_out = 16'($urandom);
    repeat (3) tick();
    run_step(8'd0, 1, "step256");
    pulse_load();
    checks_total++; if (dut_in !== dut_in_m) $display("FAIL busy_write_applied_later: got %h want %h", dut_in, dut_in_m); else checks_passed++;
  endtask

  task automatic test_back_to_back();
    write_byte(3'd1, 8'($urandom));
    dut_out = 16'($urandom);
    repeat (3) tick();
    run_step(8'd2, 0, "b2b_a");
    run_step(8'd1, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_write_load();
    test_get();
    test_priority();
    test_step_basic();
    test_capture_window();
    test_reset_abort();
    test_random_steps();
    test_long_step();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/emu_chip_tester.md
EMU_CHIP_TESTER -- requirements
Module: emu_chip_tester

Interface
REQ-001 Parameter NUM_STIM_BYTES, default 2, number of 8-bit stimulus bytes driven to the DUT.
REQ-002 Parameter NUM_OUT_BYTES, default 2, number of 8-bit capture bytes sampled from the DUT.
REQ-003 Parameter ADDR_W, default 3, width of Addr_emu; 2**ADDR_W SHALL be greater than NUM_OUT_BYTES.
REQ-004 Parameter HALF_CYC, default 1, clk_emu cycles per xclk_dut half-period, range 1..255.
REQ-005 clk_emu  in  1  the single clock; all logic is clocked on its rising edge.
REQ-006 reset_emu  in  1  reset, synchronous and active-high.
REQ-007 Din_emu  in  8  host write data; also the step count on step_emu.
REQ-008 Addr_emu  in  ADDR_W  byte index for stimulus write and capture/status read.
REQ-009 wr_emu  in  1  write Din_emu into stimulus shadow byte Addr_emu.
REQ-010 load_emu  in  1  copy the shadow bank to dut_in.
REQ-011 get_emu  in  1  copy synchronised dut_out into the capture bank.
REQ-012 step_emu  in  1  start an automatic load/clock/capture sequence.
REQ-013 Dout_emu  out  8  registered read data.
REQ-014 busy_emu  out  1  high while a step sequence runs.
REQ-015 dut_in  out  8*NUM_STIM_BYTES  registered DUT stimulus; byte k is bits [8k+7:8k].
REQ-016 dut_out  in  8*NUM_OUT_BYTES  asynchronous DUT pin outputs.
REQ-017 xclk_dut  out  1  registered controlled DUT clock.

Function
REQ-018 Each dut_out bit SHALL pass through a two-flop synchroniser before any capture.
REQ-019 Command priority SHALL be: step_emu > load_emu > get_emu. wr_emu and the read path SHALL act independently of these commands.
REQ-020 Writes with Addr_emu >= NUM_STIM_BYTES SHALL be ignored. Shadow writes are allowed while busy; they are applied only by the next load or step.
REQ-021 Reads: Dout_emu SHALL update every cycle, 1 cycle after Addr_emu. Address a < NUM_OUT_BYTES returns capture byte a. Address NUM_OUT_BYTES returns status {6'b0, done, busy_emu}. Any other address returns 8'h00.
REQ-022 FSM states: IDLE, APPLY, CLK_HI, CLK_LO, SETTLE, CAPTURE.
REQ-023 IDLE: step_emu loads the cycle counter with Din_emu (0 means 256), clears done, and moves to APPLY. busy_emu SHALL be high from the next cycle.
REQ-024 APPLY (1 cycle): dut_in takes the shadow bank; go to CLK_HI.
REQ-025 CLK_HI: xclk_dut=1 for HALF_CYC cycles, then go to CLK_LO.
REQ-026 CLK_LO: xclk_dut=0 for HALF_CYC cycles, then decrement the counter. If the result is nonzero, return to CLK_HI; otherwise go to SETTLE.
REQ-027 SETTLE: wait 3 cycles to cover synchroniser latency, then go to CAPTURE.
REQ-028 CAPTURE (1 cycle): capture bank takes synchronised dut_out, done=1, return to IDLE; busy_emu falls on the next cycle.
REQ-029 load_emu, get_emu and step_emu SHALL be ignored while busy_emu=1.
REQ-030 In IDLE, xclk_dut SHALL stay 0. Manual load/get SHALL take effect on the next clk_emu edge.
REQ-031 done SHALL be sticky until the next accepted step_emu or reset.

Reset
REQ-032 reset_emu SHALL take effect at any clk_emu edge, including mid-sequence. It aborts to IDLE with no capture.
REQ-033 Reset values: dut_in=0, shadow bank=0, capture bank=0, synchronisers=0, Dout_emu=8'h00, xclk_dut=0, busy_emu=0, done=0, counters=0.

Structure
REQ-034 Shared package emu_pkg SHALL hold the FSM state enum, the status bit positions, and the SETTLE_CYC=3 constant.
REQ-035 The clock-stepping FSM and its counters SHALL be one sub-module, emu_clk_stepper, with ports for start, count, and done, plus xclk_dut, apply and capture strobes.

Verification
REQ-036 Reset, then read address 2 (NUM_OUT_BYTES=2) -> Dout_emu=8'h00, busy_emu=0, xclk_dut=0.
REQ-037 Write 8'hA5 to addr 0 and 8'h3C to addr 1, then pulse load_emu -> dut_in=16'h3CA5 one cycle later. A write to addr 5 leaves both shadow bytes unchanged.
REQ-038 With HALF_CYC=2, step_emu with Din_emu=3 -> exactly 3 xclk_dut pulses, each 2 high + 2 low cycles. busy_emu is high for 1+12+3+1 cycles, then status reads 8'h02.
REQ-039 Hold dut_out=16'hBEEF and step with count 1 -> capture addr 0 reads 8'hEF and addr 1 reads 8'hBE. Changing dut_out during SETTLE cycle 3 is not captured.
REQ-040 Assert reset_emu during the second CLK_HI of a count-4 step -> next cycle busy_emu=0, xclk_dut=0, done=0, capture bank unchanged from reset (0).
REQ-041 Pulse step_emu with Din_emu=0 -> 256 xclk_dut pulses. A concurrent load_emu during busy is ignored: dut_in keeps the value applied in APPLY.
